// File: rtl/a23_out_pkg.sv
// Shared types and constants for the A23 output drain engine.
// The stream is one count header word followed by the output memory words.
package a23_out_pkg;
  localparam int A23_WORD_W = 32;
  // Stream position of the cycle-count header; memory words follow it.
  localparam int HDR_POS = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE
  } st_e;
endpackage

// File: rtl/a23_out_buf.sv
// Snapshot of the core output memory, captured in one cycle on cap.
// Read through an indexed word port.
module a23_out_buf
  import a23_out_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        cap,
  input  logic [DEPTH*A23_WORD_W-1:0] o,
  input  logic [IDX_W-1:0]            idx,
  output logic [A23_WORD_W-1:0]       rd_data
);
  logic [DEPTH-1:0][A23_WORD_W-1:0] mem;

  // Contents are meaningless after reset, so the bank carries no reset.
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    always_ff @(posedge clk) begin
      if (cap) mem[w] <= o[w*A23_WORD_W +: A23_WORD_W];
    end
  end

  assign rd_data = mem[idx];
endmodule

// File: rtl/a23_out_streamer.sv
// Counts core run cycles; on terminate, snapshots the output memory and
// streams {count, word 0 .. word N-1} over a valid/ready word stream.
module a23_out_streamer
  import a23_out_pkg::*;
#(
  parameter int OUT_MEM_SIZE = 64,
  parameter int CC_WIDTH     = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               core_run,
  input  logic                               terminate,
  input  logic [OUT_MEM_SIZE*A23_WORD_W-1:0] o,
  output logic                               m_valid,
  output logic [A23_WORD_W-1:0]              m_data,
  output logic                               m_last,
  input  logic                               m_ready,
  output logic                               done
);
  localparam int IDX_W = $clog2(OUT_MEM_SIZE);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(OUT_MEM_SIZE - 1);
  localparam logic [CC_WIDTH-1:0] CC_MAX   = '1;

  st_e                   state;
  logic [CC_WIDTH-1:0]   cnt;
  logic [IDX_W-1:0]      idx;
  logic [A23_WORD_W-1:0] rd_word;
  logic                  cap;
  logic                  hs;

  assign cap = (state == S_IDLE) && core_run && terminate;
  assign hs  = m_valid && m_ready;

  a23_out_buf #(.DEPTH(OUT_MEM_SIZE), .IDX_W(IDX_W)) u_buf (
    .clk    (clk),
    .cap    (cap),
    .o      (o),
    .idx    (idx),
    .rd_data(rd_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!core_run) cnt <= '0;
          else if (terminate) begin
            state   <= S_HDR;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
          end else if (cnt != CC_MAX) cnt <= cnt + 1'b1;
        end
        S_HDR: begin
          if (hs) begin
            state <= S_DATA;
            idx   <= '0;
          end
        end
        S_DATA: begin
          // Last-word test precedes the increment, so idx never wraps.
          if (hs) begin
            if (idx == LAST_IDX) begin
              state   <= S_DONE;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx    <= idx + 1'b1;
              m_last <= (idx == LAST_IDX - 1'b1);
            end
          end
        end
        S_DONE: begin
          if (!core_run) begin
            state <= S_IDLE;
            done  <= 1'b0;
            cnt   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    m_data = '0;
    case (state)
      S_HDR:   m_data = A23_WORD_W'(cnt);
      S_DATA:  m_data = rd_word;
      default: m_data = '0;
    endcase
  end
endmodule

// File: tb/tb_a23_out_streamer.sv
// Self-checking bench for a23_out_streamer: job table plus hand sequences,
// stream words checked against a scoreboard filled when terminate is driven.
module tb_a23_out_streamer;
  localparam int N = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            core_run;
  logic            terminate;
  logic [N*32-1:0] o;
  logic            m_valid;
  logic [31:0]     m_data;
  logic            m_last;
  logic            m_ready;
  logic            done;

  a23_out_streamer #(.OUT_MEM_SIZE(N), .CC_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .core_run (core_run),
    .terminate(terminate),
    .o        (o),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  typedef struct {
    int          run;
    logic [31:0] base;
    int          rmode;
    bit          corrupt;
    bit          drop_run;
    logic [31:0] exp_hdr;
  } job_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   acc_cnt = 0;
  int   rmode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Ready pattern generator: 0 = always, 1 = one cycle in three, 2 = random.
  initial begin
    int cyc = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor: samples at negedge; a handshake seen here completes on the next posedge.
  initial begin
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [31:0] prev_d = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          checks++;
          if (!(m_valid && m_data === prev_d && m_last === prev_l)) begin
            errors++;
            $display("FAIL hold_stable: valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                     m_valid, m_data, m_last, prev_d, prev_l);
          end
        end
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got data=%h, expected no word", m_data);
          end else begin
            e = sb.pop_front();
            checks++;
            if (m_data !== e.d || m_last !== e.l) begin
              errors++;
              $display("FAIL word%0d: data=%h last=%b, expected data=%h last=%b",
                       acc_cnt, m_data, m_last, e.d, e.l);
            end
          end
          acc_cnt++;
        end
        prev_v = m_valid;
        prev_r = m_ready;
        prev_d = m_data;
        prev_l = m_last;
      end
    end
  end

  task automatic start_job(input int run, input logic [31:0] base, input logic [31:0] exp_hdr,
                           input bit corrupt, input bit drop_run);
    exp_t e;
    core_run  = 1'b0;
    terminate = 1'b0;
    for (int i = 0; i < N; i++) o[32*i +: 32] = base + 32'(i);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_valid", 32'(m_valid), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    acc_cnt  = 0;
    core_run = 1'b1;
    repeat (run) begin
      @(posedge clk);
      #1;
    end
    terminate = 1'b1;
    e.d = exp_hdr;
    e.l = 1'b0;
    sb.push_back(e);
    for (int i = 0; i < N; i++) begin
      e.d = base + 32'(i);
      e.l = (i == N - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    terminate = 1'b0;
    chk("capture_latency", 32'(m_valid), 32'd1);
    if (corrupt) o = '1;
    if (drop_run) core_run = 1'b0;
  endtask

  task automatic finish_job();
    int k = 0;
    while (sb.size() != 0 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: %0d words left, expected 0", sb.size());
      sb.delete();
    end
    chk("word_count", 32'(acc_cnt), 32'(N + 1));
    chk("done_rise", 32'(done), 32'd1);
    chk("done_valid", 32'(m_valid), 32'd0);
    core_run = 1'b0;
    @(posedge clk);
    #1;
    chk("done_fall", 32'(done), 32'd0);
  endtask

  job_t jobs[5];

  initial begin
    jobs[0] = '{37,  32'hA500_0000, 0, 1'b0, 1'b0, 32'd37};
    jobs[1] = '{37,  32'hA500_0000, 1, 1'b0, 1'b0, 32'd37};
    jobs[2] = '{12,  32'h3C00_0000, 0, 1'b1, 1'b0, 32'd12};
    jobs[3] = '{0,   32'h7700_0100, 2, 1'b0, 1'b1, 32'd0};
    jobs[4] = '{200, 32'h0BAD_F000, 2, 1'b1, 1'b1, 32'd200};

    rst = 1'b0;
    core_run = 1'b0;
    terminate = 1'b0;
    o = '0;
    #2;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int j = 0; j < 5; j++) begin
      rmode = jobs[j].rmode;
      start_job(jobs[j].run, jobs[j].base, jobs[j].exp_hdr, jobs[j].corrupt, jobs[j].drop_run);
      finish_job();
    end

    // terminate without core_run must not start a dump or count
    rmode = 0;
    core_run = 1'b0;
    terminate = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("term_norun_valid", 32'(m_valid), 32'd0);
    end
    terminate = 1'b0;
    start_job(5, 32'h5500_0000, 32'd5, 1'b0, 1'b0);
    finish_job();

    // async reset mid-stream, then a clean short run
    start_job(20, 32'h5E00_0000, 32'd20, 1'b0, 1'b0);
    begin
      int k = 0;
      while (acc_cnt < 10 && k < 500) begin
        @(posedge clk);
        k++;
      end
      chk("reset_wait", 32'(acc_cnt >= 10), 32'd1);
    end
    #1;
    rst = 1'b0;
    core_run = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_last", 32'(m_last), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_data", m_data, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("arst_hold", 32'(m_valid), 32'd0);
    start_job(3, 32'hC300_0000, 32'd3, 1'b0, 1'b0);
    finish_job();

    // drop core_run in DONE, then a 2-cycle run
    start_job(2, 32'h2200_0000, 32'd2, 1'b0, 1'b0);
    finish_job();

    repeat (3) @(posedge clk);
    #1;
    chk("final_idle", 32'(m_valid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/a23_out_streamer.md
# a23_out_streamer

Drain engine at the output end of the A23 garbled-circuit core. It takes the flat `o` output-memory bus and the `terminate` flag from `a23_gc_main`, and counts core run cycles. When the core terminates, it snapshots the output memory and streams a cycle-count header followed by every output word over a valid/ready word stream. This replaces simulation-only memory dumps with a synthesizable result path toward the host interface.

## Interface
- `OUT_MEM_SIZE`, 64: number of 32-bit output words on `o`; must be ≥ 2.
- `CC_WIDTH`, 32: cycle counter width, ≤ 32. The counter is zero-extended into the header word.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `core_run`  in  1  high while the core is out of reset and executing.
- `terminate`  in  1  core halt flag from `a23_gc_main`.
- `o`  in  OUT_MEM_SIZE*32  flat output memory. Word i occupies bits `[32*(i+1)-1:32*i]`.
- `m_valid`  out  1  stream word valid.
- `m_data`  out  32  stream word.
- `m_last`  out  1  high on the final word of a dump.
- `m_ready`  in  1  downstream accept.
- `done`  out  1  high from the last accepted word until the next job.

## Operation
- FSM states: IDLE, HDR, DATA, DONE.
- **IDLE, cycle counter:**
  - Clears to 0 on each edge with `core_run`=0.
  - Increments on each edge with `core_run`=1 and `terminate`=0.
  - Saturates at 2^CC_WIDTH-1; no wrap.
- **IDLE → HDR:** on an edge where `core_run`=1 and `terminate`=1.
  - On that same edge: all of `o` is copied into the snapshot buffer, and the counter freezes.
  - `terminate` with `core_run`=0 is ignored.
- **HDR:**
  - `m_valid`=1, `m_data` = zero-extended count, `m_last`=0.
  - On `m_valid && m_ready`: go to DATA, word index = 0.
- **DATA:**
  - `m_data` = snapshot word[index].
  - `m_last` = (index == OUT_MEM_SIZE-1).
  - On a handshake: index increments; on the last word go to DONE.
- **DONE:**
  - `m_valid`=0, `done`=1.
  - Return to IDLE on the first edge with `core_run`=0; the counter clears there.
- **Handshake rules:**
  - Once `m_valid` is asserted, it and `m_data`/`m_last` stay stable until accepted.
  - `m_valid` never depends combinationally on `m_ready`.
- **Changes after capture:** after the snapshot, changes on `o`, `terminate` or `core_run` do not alter streamed data. Exception: `core_run` low during HDR/DATA is ignored until DONE.
- **Reset:**
  - Asserting `rst` mid-stream forces IDLE immediately, with `m_valid`=0, `m_last`=0, `done`=0, counter=0 and index=0.
  - Snapshot contents are don't-care after reset.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `done`=0, state IDLE.
- All outputs are registered, or decoded only from registered state plus the snapshot.
- Capture latency: `m_valid` rises 1 cycle after the edge that samples `terminate`=1.
- Throughput: with `m_ready` held high, one word per cycle. A full dump is OUT_MEM_SIZE+1 cycles of `m_valid`.
- `done` rises on the cycle after the last handshake.
- The count equals the number of rising edges with `core_run`=1 before `terminate` is seen. This matches the testbench `cc` convention.
- Index width: `$clog2(OUT_MEM_SIZE)`. The index never wraps, because the last-word check precedes the increment.

## Structure
- **Package `a23_out_pkg`:**
  - State enum (IDLE/HDR/DATA/DONE).
  - `A23_WORD_W` = 32.
  - Header position constant (word 0 = count).
- **Sub-module `a23_out_buf`:**
  - Snapshot register bank with capture enable.
  - Word read port, indexed.
- **Top level:** keeps the FSM, the counter and the stream registers.

## Test plan
- Hold `core_run`=1 for 37 edges, then raise `terminate`; set `o` word i = 0xA5000000+i; `m_ready`=1. Required: stream 37, 0xA5000000, …, 0xA500003F; `m_last` only on 0xA500003F; `done`=1 one cycle later.
- Backpressure: toggle `m_ready` in a 1-in-3 pattern. Required: identical sequence, no drops or duplicates, and `m_data` stable while `m_valid`=1 and `m_ready`=0.
- Change `o` to all-ones on the cycle after capture. Required: streamed data is still the pre-capture values.
- Raise `terminate` with `core_run`=0. Required: no stream and the counter stays 0. Then a normal run of 5 cycles. Required: header 5.
- Assert `rst` after 10 accepted words. Required: `m_valid`=0 asynchronously and the state returns to IDLE. Then a new run of 3 cycles. Required: header 3 and a full 65-word dump.
- Drop `core_run` in DONE, then run 2 cycles and terminate. Required: header 2; `done` falls on the IDLE re-entry.
